hog_feature_stream_reader: RTL
==============================

// Module: hog_feature_stream_reader
// PURPOSE
//  Streams one full HOG feature frame out of NBANK 1-cycle-latency result BRAMs. Each QN-bit
//  unsigned fraction is converted to IEEE-754 float32, and the floats are packed into AXI_DW-bit
//  words. Words leave through a valid/ready stream with an internal word FIFO, so backpressure
//  never loses data. Sits between the HOG result banks and the AXI write master.
// PARAMETERS
//  RAM_AW         17   BRAM address width
//  QN             8    fixed-point fraction bits per stored value (2..23)
//  NBANK          4    number of result banks (power of 2)
//  AXI_DW         512  output word width; must be a multiple of 32*NBANK
//  NBIN           31   bins per frame
//  ADDR_PER_BIN   256  addresses per bin per bank; must be a multiple of BEATS
//  GRP0_END       17   last bin of rotation group 0
//  GRP1_END       26   last bin of rotation group 1; group 2 is GRP1_END+1..NBIN-1
//  ROT0/ROT1/ROT2 0/1/3  bank rotation for groups 0/1/2
//  OUT_DEPTH      4    word FIFO depth (power of 2, >=2)
// PORTS
//  aclk        in   1              clock
//  arest       in   1              synchronous reset, active-high
//  start       in   1              pulse: begin one frame (ignored while busy)
//  busy        out  1              frame in progress
//  done        out  1              1-cycle pulse when the last word is accepted
//  res_enb     out  NBANK          per-bank read enable (all bits equal)
//  res_addrb   out  NBANK*RAM_AW   per-bank read address (all fields equal)
//  res_doutb   in   NBANK*QN       per-bank read data, valid 1 cycle after enb
//  m_data      out  AXI_DW         output word
//  m_valid     out  1              output word valid
//  m_ready     in   1              consumer ready
//  test_mode   in   1              present only with HOG_RD_TEST_PATTERN_EN
// BEHAVIOUR
//  - Derived constants:
//    - BEATS = AXI_DW/(32*NBANK); defaults give 4
//    - NADDR = NBIN*ADDR_PER_BIN; defaults give 7936
//    - NWORD = NADDR/BEATS; defaults give 1984
//  - Reset: all state cleared on the clock edge while arest=1.
//    - busy, done, m_valid, res_enb = 0; res_addrb = 0; m_data = 0; FIFO emptied.
//    - Reset mid-frame aborts the frame: no done pulse, no further reads.
//  - FSM states and transitions:
//    - IDLE -> RUN on start.
//    - RUN -> DRAIN after read address NADDR-1 is issued.
//    - DRAIN -> IDLE when the FIFO is empty and the final word is accepted; done pulses on that cycle.
//    - busy = (state != IDLE).
//  - Reads:
//    - A word's BEATS reads issue on consecutive cycles, one address per cycle.
//    - A new word starts only if FIFO free entries exceed the number of words already in flight.
//    - Once started, a word is never interrupted.
//    - Address increments by 1 per read and returns to 0 in IDLE.
//  - Timing:
//    - With m_ready=1, start in cycle 0 gives reads in cycles 1..BEATS.
//    - First m_valid is in cycle BEATS+2.
//    - Sustained rate is 1 word per BEATS cycles.
//  - Conversion (combinational on res_doutb, per bank):
//    - Value is v/2^QN. v=0 -> 32'h0.
//    - Otherwise, with k = index of the leading 1: sign 0, exponent 127-(QN-k),
//      mantissa = bits below k, MSB-aligned and zero-filled. Exact, no rounding needed.
//  - Packing:
//    - Rotation group is chosen by the bin of the read address (addr/ADDR_PER_BIN).
//    - Per beat, lane j (32 bits) = float of bank (j+ROT)%NBANK.
//    - Beat 0 occupies the lowest NBANK*32 bits of the word (little-endian).
//  - Stream:
//    - m_data is held stable while m_valid=1 and m_ready=0.
//    - Transfer happens when m_valid & m_ready.
//    - A FIFO push and pop in the same cycle are both honoured.
//  - Edge cases:
//    - start while busy: ignored.
//    - start on the same cycle as the done pulse: ignored.
//    - m_ready held low indefinitely: reads stall at a word boundary; no overflow.
// CONFIGURATION
//  HOG_RD_TEST_PATTERN_EN defined:
//    - test_mode port exists. While test_mode=1, every 32-bit lane of word n = n (the word index
//      within the frame); timing and BRAM reads are unchanged.
//  HOG_RD_TEST_PATTERN_EN undefined:
//    - test_mode port is absent and the block produces only converted data.
// TESTING
//  1. All banks hold 8'h80, m_ready=1, start
//     -> 1984 words, every lane 32'h3F000000; done exactly once, right after the last transfer.
//  2. Conversion sweep, bank0 values 8'h01/8'hC0/8'h00/8'hFF
//     -> 32'h3B800000/32'h3F400000/32'h0/32'h3F7F0000.
//  3. Bank b at addr a holds (a*4+b)&8'hFF
//     -> bin0 word0 lanes ordered bank0..3; bin18 lane0 = bank1; bin27 lane0 = bank3.
//  4. m_ready toggling 1-in-3 plus a 200-cycle stall
//     -> no lost or duplicated words; m_data stable while stalled; res_enb idle during the stall.
//  5. arest asserted at word 500, then start
//     -> outputs zero the next cycle, no done; the new frame begins at addr 0.
//  6. HOG_RD_TEST_PATTERN_EN defined, test_mode=1
//     -> word 7 lanes all 32'd7; last word lanes all 32'd1983.

Source files
------------

// File: rtl/hog_feature_stream_reader.sv
// hog_feature_stream_reader: reads one HOG frame from NBANK result BRAMs, converts each value to float32
// and streams packed words through a small FIFO. Optional macro HOG_RD_TEST_PATTERN_EN adds test_mode.
module hog_feature_stream_reader #(
    parameter int RAM_AW       = 17,
    parameter int QN           = 8,
    parameter int NBANK        = 4,
    parameter int AXI_DW       = 512,
    parameter int NBIN         = 31,
    parameter int ADDR_PER_BIN = 256,
    parameter int GRP0_END     = 17,
    parameter int GRP1_END     = 26,
    parameter int ROT0         = 0,
    parameter int ROT1         = 1,
    parameter int ROT2         = 3,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                    aclk,
    input  logic                    arest,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [NBANK-1:0]        res_enb,
    output logic [NBANK*RAM_AW-1:0] res_addrb,
    input  logic [NBANK*QN-1:0]     res_doutb,
    output logic [AXI_DW-1:0]       m_data,
    output logic                    m_valid,
`ifdef HOG_RD_TEST_PATTERN_EN
    input  logic                    test_mode,
`endif
    input  logic                    m_ready
);
    localparam int BEATS  = AXI_DW / (32 * NBANK);
    localparam int NADDR  = NBIN * ADDR_PER_BIN;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW     = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int PW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW     = PW + 1;
    localparam int G0_LIM = (GRP0_END + 1) * ADDR_PER_BIN;
    localparam int G1_LIM = (GRP1_END + 1) * ADDR_PER_BIN;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                  state_r, next_state_s;
    logic [RAM_AW-1:0]       addr_cnt_r, addr_r;
    logic                    enb_r, done_r, dv_r;
    logic [BW-1:0]           beat_r, ibeat_r, dbeat_r;
    logic [RW-1:0]           rot_s, rot_r, drot_r;
    logic [CW-1:0]           infl_r, cnt_r, free_s;
    logic [PW-1:0]           wp_r, rp_r;
    logic                    issue_s, start_word_s, push_s, pop_s;
    logic [NBANK*32-1:0]     beat_s;
    logic [AXI_DW-1:0]       word_r, word_s, push_data_s;
    logic [AXI_DW-1:0]       mem_r [OUT_DEPTH];

    // Exact conversion: every QN-bit fraction fits in a float32 mantissa.
    function automatic logic [31:0] to_f32(input logic [QN-1:0] v);
        logic [4:0]  k;
        logic [7:0]  ex;
        logic [22:0] man;
        k = 5'd0;
        for (int i = 0; i < QN; i++) begin
            k = v[i] ? 5'(i) : k;
        end
        ex  = 8'(127 - QN) + {3'b000, k};
        man = 23'(v) << (5'd23 - k);
        return (v == '0) ? 32'h0000_0000 : {1'b0, ex, man};
    endfunction

    assign busy      = (state_r != IDLE);
    assign done      = done_r;
    assign res_enb   = {NBANK{enb_r}};
    assign res_addrb = {NBANK{addr_r}};
    assign m_valid   = (cnt_r != '0);
    assign m_data    = mem_r[rp_r];

    // Next state, read issue, lane rotation and word assembly.
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        start_word_s = 1'b0;
        free_s       = CW'(OUT_DEPTH) - cnt_r;
        pop_s        = (cnt_r != '0) && m_ready;
        push_s       = dv_r && (dbeat_r == BW'(BEATS - 1));
        if (addr_cnt_r < RAM_AW'(G0_LIM)) begin
            rot_s = RW'(ROT0);
        end else if (addr_cnt_r < RAM_AW'(G1_LIM)) begin
            rot_s = RW'(ROT1);
        end else begin
            rot_s = RW'(ROT2);
        end
        beat_s = '0;
        for (int j = 0; j < NBANK; j++) begin
            beat_s[j*32 +: 32] = to_f32(res_doutb[((j + int'(drot_r)) % NBANK)*QN +: QN]);
        end
        word_s = word_r;
        if (dv_r) begin
            word_s[int'(dbeat_r)*NBANK*32 +: NBANK*32] = beat_s;
        end else begin
            word_s = word_r;
        end
        case (state_r)
            IDLE: begin
                // done_r is still high on the first idle cycle, so a start coinciding with done is dropped
                if (start && !done_r) begin
                    next_state_s = RUN;
                    issue_s      = 1'b1;
                    start_word_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (beat_r != '0) begin
                    issue_s = 1'b1;
                end else if (free_s > infl_r) begin
                    issue_s      = 1'b1;
                    start_word_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
                if (issue_s && (addr_cnt_r == RAM_AW'(NADDR - 1))) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = RUN;
                end
            end
            DRAIN: begin
                if ((cnt_r == CW'(1)) && (infl_r == '0) && pop_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

`ifdef HOG_RD_TEST_PATTERN_EN
    localparam int LANES = AXI_DW / 32;
    logic [31:0] wcnt_r;

    // Index of the next word pushed within the current frame.
    always_ff @(posedge aclk) begin
        if (arest) begin
            wcnt_r <= 32'd0;
        end else if (state_r == IDLE) begin
            wcnt_r <= 32'd0;
        end else if (push_s) begin
            wcnt_r <= wcnt_r + 32'd1;
        end
    end

    assign push_data_s = test_mode ? {LANES{wcnt_r}} : word_s;
`else
    assign push_data_s = word_s;
`endif

    // State register and read-issue pipeline.
    always_ff @(posedge aclk) begin
        if (arest) begin
            state_r    <= IDLE;
            addr_cnt_r <= '0;
            addr_r     <= '0;
            enb_r      <= 1'b0;
            beat_r     <= '0;
            ibeat_r    <= '0;
            rot_r      <= '0;
            infl_r     <= '0;
            done_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            enb_r   <= issue_s;
            done_r  <= (state_r == DRAIN) && (next_state_s == IDLE);
            infl_r  <= infl_r + CW'(start_word_s) - CW'(push_s);
            if (issue_s) begin
                addr_r     <= addr_cnt_r;
                addr_cnt_r <= addr_cnt_r + RAM_AW'(1);
                beat_r     <= (beat_r == BW'(BEATS - 1)) ? '0 : beat_r + BW'(1);
                ibeat_r    <= beat_r;
                rot_r      <= rot_s;
            end else if (state_r == IDLE) begin
                addr_r     <= '0;
                addr_cnt_r <= '0;
                beat_r     <= '0;
            end
        end
    end

    // Beat metadata follows the read data by one cycle; partial word accumulates here.
    always_ff @(posedge aclk) begin
        if (arest) begin
            dv_r    <= 1'b0;
            dbeat_r <= '0;
            drot_r  <= '0;
            word_r  <= '0;
        end else begin
            dv_r    <= enb_r;
            dbeat_r <= ibeat_r;
            drot_r  <= rot_r;
            word_r  <= word_s;
        end
    end

    // Output word FIFO; issue throttling guarantees a push never finds it full.
    always_ff @(posedge aclk) begin
        if (arest) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wp_r  <= '0;
            rp_r  <= '0;
            cnt_r <= '0;
        end else begin
            if (push_s) begin
                mem_r[wp_r] <= push_data_s;
                wp_r        <= wp_r + PW'(1);
            end
            if (pop_s) begin
                rp_r <= rp_r + PW'(1);
            end
            cnt_r <= cnt_r + CW'(push_s) - CW'(pop_s);
        end
    end
endmodule
